// File: rtl/puf_pkg.sv
// Shared definitions for the arbiter PUF voter, bench and wrappers.
package puf_pkg;

    localparam int unsigned CHAL_W = 16;
    localparam int unsigned RESP_W = 4;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StLaunch = 3'd1,
        StSettle = 3'd2,
        StSample = 3'd3,
        StDone   = 3'd4
    } puf_state_e;

endpackage

// File: rtl/puf_bit_counter.sv
// Ones counter for a single PUF response bit: cleared at the start of a run,
// incremented on each sample cycle in which the bit reads 1.
module puf_bit_counter #(
    parameter int unsigned CntW = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clr_i,
    input  logic            inc_i,
    input  logic            bit_i,
    output logic [CntW-1:0] cnt_o
);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Next count: clear has priority over counting.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && bit_i) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/puf_response_voter.sv
// Majority voter for an arbiter PUF: fires the PUF NUM_SAMPLES times per
// challenge, counts ones per response bit and reports the majority value and
// a per-bit instability flag.
module puf_response_voter
    import puf_pkg::*;
#(
    parameter int unsigned NUM_SAMPLES   = 15,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [CHAL_W-1:0] challenge,
    output logic [CHAL_W-1:0] puf_challenge,
    output logic              puf_fire,
    input  logic [RESP_W-1:0] puf_resp,
    output logic              busy,
    output logic              done,
    output logic [RESP_W-1:0] response,
    output logic [RESP_W-1:0] unstable
);

    localparam int unsigned CNT_W = $clog2(NUM_SAMPLES + 1);
    // Settle counter is sized for its own range, independent of the sample count.
    localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] NUM_S = CNT_W'(NUM_SAMPLES);
    localparam logic [CNT_W-1:0] HALF_S = CNT_W'(NUM_SAMPLES / 2);

    if ((NUM_SAMPLES % 2 == 0) || (NUM_SAMPLES > 255) ||
        (SETTLE_CYCLES == 0) || (SETTLE_CYCLES > 255)) begin : g_bad_param
        $error("puf_response_voter: illegal NUM_SAMPLES or SETTLE_CYCLES");
    end

    puf_state_e        state_q, state_d;
    logic [SET_W-1:0]  settle_q, settle_d;
    logic [CNT_W-1:0]  smp_q, smp_d;
    logic [CHAL_W-1:0] chal_q, chal_d;
    logic [RESP_W-1:0] resp_q, resp_d;
    logic [RESP_W-1:0] unst_q, unst_d;

    logic              cnt_clr;
    logic              cnt_inc;
    logic [CNT_W-1:0]  ones     [RESP_W];
    logic [CNT_W-1:0]  ones_fin [RESP_W];

    for (genvar g = 0; g < RESP_W; g++) begin : g_ones
        puf_bit_counter #(
            .CntW (CNT_W)
        ) u_cnt (
            .clk_i (CLK),
            .rst_i (RST),
            .clr_i (cnt_clr),
            .inc_i (cnt_inc),
            .bit_i (puf_resp[g]),
            .cnt_o (ones[g])
        );
    end

    // Ones count including the sample being taken this cycle; used for the final vote.
    always_comb begin
        for (int i = 0; i < RESP_W; i++) begin
            ones_fin[i] = ones[i] + CNT_W'(puf_resp[i]);
        end
    end

    // Next-state logic for the sequencing FSM and its datapath registers.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        smp_d    = smp_q;
        chal_d   = chal_q;
        resp_d   = resp_q;
        unst_d   = unst_q;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    chal_d  = challenge;
                    smp_d   = '0;
                    cnt_clr = 1'b1;
                    state_d = StLaunch;
                end
            end
            StLaunch: begin
                settle_d = SET_W'(SETTLE_CYCLES - 1);
                state_d  = StSettle;
            end
            StSettle: begin
                if (settle_q == '0) begin
                    state_d = StSample;
                end else begin
                    settle_d = settle_q - SET_W'(1);
                end
            end
            StSample: begin
                cnt_inc = 1'b1;
                smp_d   = smp_q + CNT_W'(1);
                if (smp_d == NUM_S) begin
                    state_d = StDone;
                    for (int i = 0; i < RESP_W; i++) begin
                        resp_d[i] = ones_fin[i] > HALF_S;
                        unst_d[i] = (ones_fin[i] != '0) && (ones_fin[i] != NUM_S);
                    end
                end else begin
                    state_d = StLaunch;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; reset abandons any run in progress.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= StIdle;
            settle_q <= '0;
            smp_q    <= '0;
            chal_q   <= '0;
            resp_q   <= '0;
            unst_q   <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            smp_q    <= smp_d;
            chal_q   <= chal_d;
            resp_q   <= resp_d;
            unst_q   <= unst_d;
        end
    end

    assign puf_challenge = chal_q;
    assign puf_fire      = (state_q == StLaunch);
    assign busy          = (state_q != StIdle);
    assign done          = (state_q == StDone);
    assign response      = resp_q;
    assign unstable      = unst_q;

endmodule

// File: tb/tb_puf_response_voter.sv
// Scoreboard bench for puf_response_voter: default-parameter DUT driven by a
// behavioural PUF model, plus a minimum-parameter DUT.
module tb_puf_response_voter;
    import puf_pkg::*;

    typedef struct {
        logic [3:0]  resp;
        logic [3:0]  unst;
        logic [15:0] chal;
        int unsigned done_cyc;
        int unsigned fires;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] challenge;
    logic [15:0] puf_challenge;
    logic        puf_fire;
    logic [3:0]  puf_resp;
    logic        busy;
    logic        done;
    logic [3:0]  response;
    logic [3:0]  unstable;

    logic        start_s;
    logic [15:0] puf_challenge_s;
    logic        puf_fire_s;
    logic [3:0]  puf_resp_s;
    logic        busy_s;
    logic        done_s;
    logic [3:0]  response_s;
    logic [3:0]  unstable_s;

    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned fire_cnt = 0;
    int unsigned done_cnt = 0;
    int unsigned fire_cnt_s = 0;
    int unsigned done_cnt_s = 0;
    logic        noisy = 1'b0;
    int unsigned bit0_ones = 0;
    exp_t        sb[$];
    exp_t        sb_s[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // PUF model: bits 3..1 fixed at 3'b101, bit0 is 1 for the first bit0_ones samples.
    assign puf_resp = noisy ? {3'b101, (fire_cnt <= bit0_ones)} : 4'b1010;

    puf_response_voter u_dut (
        .CLK           (clk),
        .RST           (rst),
        .start         (start),
        .challenge     (challenge),
        .puf_challenge (puf_challenge),
        .puf_fire      (puf_fire),
        .puf_resp      (puf_resp),
        .busy          (busy),
        .done          (done),
        .response      (response),
        .unstable      (unstable)
    );

    puf_response_voter #(
        .NUM_SAMPLES   (1),
        .SETTLE_CYCLES (1)
    ) u_dut_min (
        .CLK           (clk),
        .RST           (rst),
        .start         (start_s),
        .challenge     (challenge),
        .puf_challenge (puf_challenge_s),
        .puf_fire      (puf_fire_s),
        .puf_resp      (puf_resp_s),
        .busy          (busy_s),
        .done          (done_s),
        .response      (response_s),
        .unstable      (unstable_s)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Monitor for the default DUT: counts fires, compares results on done.
    always @(negedge clk) begin
        exp_t e;
        if (puf_fire) fire_cnt++;
        if (done) begin
            done_cnt++;
            check_eq("done_expected", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check_eq("response", 32'(response), 32'(e.resp));
                check_eq("unstable", 32'(unstable), 32'(e.unst));
                check_eq("puf_challenge", 32'(puf_challenge), 32'(e.chal));
                check_eq("done_cycle", cyc, e.done_cyc);
                check_eq("fire_count", fire_cnt, e.fires);
            end
            fire_cnt = 0;
        end
    end

    // Monitor for the minimum-parameter DUT.
    always @(negedge clk) begin
        exp_t e;
        if (puf_fire_s) fire_cnt_s++;
        if (done_s) begin
            done_cnt_s++;
            check_eq("min_done_expected", 32'(sb_s.size() != 0), 1);
            if (sb_s.size() != 0) begin
                e = sb_s.pop_front();
                check_eq("min_response", 32'(response_s), 32'(e.resp));
                check_eq("min_unstable", 32'(unstable_s), 32'(e.unst));
                check_eq("min_done_cycle", cyc, e.done_cyc);
                check_eq("min_fire_count", fire_cnt_s, e.fires);
            end
            fire_cnt_s = 0;
        end
    end

    // Drive one start pulse; done is expected 91 cycles after this negedge.
    task automatic run_start(input logic [15:0] ch, input logic [3:0] r, input logic [3:0] u);
        exp_t e;
        @(negedge clk);
        challenge = ch;
        start = 1'b1;
        e.resp = r;
        e.unst = u;
        e.chal = ch;
        e.done_cyc = cyc + 91;
        e.fires = 15;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int unsigned n_before, input int unsigned budget);
        int unsigned i = 0;
        while (done_cnt == n_before && i < budget) begin
            @(posedge clk);
            #6;
            i++;
        end
        check_eq("done_seen", 32'(done_cnt > n_before), 1);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_busy"}, 32'(busy), 0);
        check_eq({tag, "_done"}, 32'(done), 0);
        check_eq({tag, "_fire"}, 32'(puf_fire), 0);
        check_eq({tag, "_chal"}, 32'(puf_challenge), 0);
        check_eq({tag, "_resp"}, 32'(response), 0);
        check_eq({tag, "_unst"}, 32'(unstable), 0);
    endtask

    initial begin
        int unsigned n0;
        exp_t e;
        rst = 1'b1;
        start = 1'b0;
        start_s = 1'b0;
        challenge = 16'h0;
        puf_resp_s = 4'h0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        check_eq("reset_min_busy", 32'(busy_s), 0);
        rst = 1'b0;

        // Stable PUF.
        noisy = 1'b0;
        n0 = done_cnt;
        run_start(16'hF000, 4'b1010, 4'b0000);
        check_eq("busy_in_run", 32'(busy), 1);
        wait_done(n0, 200);
        @(posedge clk);
        #6;
        check_eq("done_one_cycle", 32'(done), 0);
        check_eq("idle_after_done", 32'(busy), 0);

        // Noisy bit0: 8 of 15 ones, then 7 of 15.
        noisy = 1'b1;
        bit0_ones = 8;
        n0 = done_cnt;
        run_start(16'h1234, 4'b1011, 4'b0001);
        wait_done(n0, 200);
        bit0_ones = 7;
        n0 = done_cnt;
        run_start(16'h4321, 4'b1010, 4'b0001);
        wait_done(n0, 200);

        // Busy protection: start and new challenge mid-run are ignored.
        noisy = 1'b0;
        n0 = done_cnt;
        run_start(16'hF000, 4'b1010, 4'b0000);
        for (int j = 0; j < 6; j++) begin
            repeat (8) @(negedge clk);
            start = 1'b1;
            challenge = 16'h00F0;
            @(negedge clk);
            start = 1'b0;
            check_eq("busy_chal_hold", 32'(puf_challenge), 32'h0000_F000);
        end
        wait_done(n0, 200);
        repeat (100) @(negedge clk);
        check_eq("busy_single_done", done_cnt - n0, 1);

        // Asynchronous reset during sample 5.
        n0 = done_cnt;
        run_start(16'hABCD, 4'b1010, 4'b0000);
        for (int i = 0; i < 200 && fire_cnt < 5; i++) begin
            @(negedge clk);
            #1;
        end
        check_eq("reached_sample5", fire_cnt, 5);
        @(posedge clk);
        #3;
        check_eq("busy_before_rst", 32'(busy), 1);
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        fire_cnt = 0;
        repeat (100) @(negedge clk);
        check_eq("no_done_after_rst", done_cnt, n0);
        run_start(16'h5A5A, 4'b1010, 4'b0000);
        wait_done(n0, 200);

        // Back-to-back with start held high.
        noisy = 1'b1;
        bit0_ones = 8;
        n0 = done_cnt;
        @(negedge clk);
        challenge = 16'hC0DE;
        start = 1'b1;
        e.resp = 4'b1011;
        e.unst = 4'b0001;
        e.chal = 16'hC0DE;
        e.done_cyc = cyc + 91;
        e.fires = 15;
        sb.push_back(e);
        e.resp = 4'b1010;
        e.done_cyc = cyc + 183;
        sb.push_back(e);
        wait_done(n0, 200);
        bit0_ones = 7;
        @(negedge clk);
        check_eq("b2b_idle_cycle", 32'(busy), 0);
        check_eq("b2b_resp_held", 32'(response), 32'(4'b1011));
        repeat (30) @(negedge clk);
        start = 1'b0;
        check_eq("b2b_busy2", 32'(busy), 1);
        check_eq("b2b_resp_held_mid", 32'(response), 32'(4'b1011));
        wait_done(n0 + 1, 200);

        // Minimum parameters: single sample, one settle cycle.
        for (int j = 0; j < 2; j++) begin
            n0 = done_cnt_s;
            @(negedge clk);
            puf_resp_s = (j == 0) ? 4'b0110 : 4'b1001;
            start_s = 1'b1;
            e.resp = puf_resp_s;
            e.unst = 4'b0000;
            e.chal = 16'h0;
            e.done_cyc = cyc + 4;
            e.fires = 1;
            sb_s.push_back(e);
            @(negedge clk);
            start_s = 1'b0;
            for (int i = 0; i < 20 && done_cnt_s == n0; i++) @(negedge clk);
            check_eq("min_done_seen", 32'(done_cnt_s > n0), 1);
        end

        repeat (5) @(negedge clk);
        check_eq("sb_empty", sb.size() + sb_s.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/puf_response_voter.md
PUF_RESPONSE_VOTER -- requirements
Module: puf_response_voter

Interface
REQ-001 The block SHALL have parameter NUM_SAMPLES, default 15: PUF evaluations per challenge; odd, 1..255.
REQ-002 The block SHALL have parameter SETTLE_CYCLES, default 4: wait cycles between launch and sampling; 1..255.
REQ-003 The block SHALL have port CLK, input, 1 bit: the only clock; all logic on the rising edge.
REQ-004 The block SHALL have port RST, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit: request a voted evaluation; honoured only in IDLE.
REQ-006 The block SHALL have port challenge, input, 16 bits: challenge word, latched when start is accepted.
REQ-007 The block SHALL have port puf_challenge, output, 16 bits: latched challenge driven to the upstream arbiter PUF SW input.
REQ-008 The block SHALL have port puf_fire, output, 1 bit: one-cycle launch pulse to the PUF.
REQ-009 The block SHALL have port puf_resp, input, 4 bits: raw PUF response (PUF LD output).
REQ-010 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse when response and unstable are updated.
REQ-012 The block SHALL have port response, output, 4 bits: per-bit majority-voted response.
REQ-013 The block SHALL have port unstable, output, 4 bits: per-bit flag, 1 when the samples of that bit were not unanimous.

Function
REQ-014 The FSM SHALL have states IDLE, LAUNCH, SETTLE, SAMPLE and DONE.
REQ-015 In IDLE with start=1, the block SHALL latch challenge into puf_challenge, clear the sample counter and all per-bit ones counters, and enter LAUNCH.
REQ-016 In LAUNCH the block SHALL assert puf_fire for exactly one cycle, load the settle counter with SETTLE_CYCLES-1, and enter SETTLE.
REQ-017 In SETTLE the block SHALL decrement the settle counter and enter SAMPLE on the cycle the counter reaches 0.
REQ-018 In SAMPLE the block SHALL register puf_resp, add each bit to its ones counter, and increment the sample counter.
REQ-019 From SAMPLE, the block SHALL enter DONE if the incremented sample count equals NUM_SAMPLES; otherwise it SHALL enter LAUNCH.
REQ-020 On the SAMPLE-to-DONE transition the block SHALL register response[i] = (ones[i] > NUM_SAMPLES/2) and unstable[i] = (ones[i] != 0 && ones[i] != NUM_SAMPLES).
REQ-021 In DONE the block SHALL assert done for one cycle and then return to IDLE.
REQ-022 response and unstable SHALL hold their values until the next DONE.
REQ-023 One iteration SHALL take SETTLE_CYCLES+2 cycles; if start is sampled at edge k, done SHALL be high in cycle k+1+NUM_SAMPLES*(SETTLE_CYCLES+2), i.e. k+91 with default parameters.
REQ-024 The block SHALL ignore start while busy; changes on challenge while busy SHALL NOT affect puf_challenge.
REQ-025 puf_challenge SHALL stay stable from the acceptance of start until the next start is accepted.
REQ-026 Counters SHALL be clog2(NUM_SAMPLES+1) bits wide and SHALL NOT wrap within a run.
REQ-027 Illegal parameter values (even NUM_SAMPLES, or either parameter equal to 0) SHALL fail elaboration.

Reset
REQ-028 While RST=1, the block SHALL immediately force the FSM to IDLE and drive puf_challenge, puf_fire, busy, done, response and unstable to 0, and clear all counters.
REQ-029 If RST is asserted mid-run, the run SHALL be abandoned with no done pulse; the first start after release SHALL run a full-length evaluation.

Structure
REQ-030 Package puf_pkg SHALL hold CHAL_W=16, RESP_W=4 and the FSM state enum; the Arbiter PUF bench and wrappers SHALL share it.
REQ-031 Sub-module puf_bit_counter (ones counter with clear/increment, one instance per response bit, RESP_W instances) SHALL implement the per-bit counting; the FSM stays in puf_response_voter.

Verification
REQ-032 The bench SHALL cover a stable PUF: PUF model constant 4'b1010, start with challenge 16'hF000 -> exactly 15 puf_fire pulses, puf_challenge=16'hF000, done at k+91, response=4'b1010, unstable=4'b0000.
REQ-033 The bench SHALL cover a noisy bit: bit0 is 1 in 8 of 15 samples -> response[0]=1, unstable[0]=1; rerun with 7 of 15 -> response[0]=0, unstable[0]=1; other bits unaffected.
REQ-034 The bench SHALL cover busy protection: start pulses and challenge=16'h00F0 applied mid-run -> no restart, puf_challenge stays 16'hF000, single done at k+91.
REQ-035 The bench SHALL cover reset mid-run: RST asserted asynchronously during sample 5 -> all outputs 0 before the next edge, no done; new start -> done 91 cycles later with correct result.
REQ-036 The bench SHALL cover back-to-back runs: start held high continuously -> DONE, one IDLE cycle, next LAUNCH; response holds its old value until the second done.
REQ-037 The bench SHALL cover minimum parameters: NUM_SAMPLES=1, SETTLE_CYCLES=1 -> done at k+4, response equals the single sample, unstable=4'b0000.
